// File: rtl/osnt_sume_ts_capture.sv
// osnt_sume_ts_capture
// Receive-side pulse timestamper. The external pin is synchronised and glitch
// filtered. Each qualified edge is stamped with STAMP_COUNTER, backdated to the
// edge at which the pin was first sampled. The stamps are queued in a
// first-word-fall-through FIFO, and event and overflow statistics are kept.
// Event pipeline: event register at edge E, write stage at E+1, FIFO commit at
// E+2. This gives a pin-to-valid latency of GLITCH_FILTER+3 clocks.
module osnt_sume_ts_capture #(
    parameter int TIMESTAMP_WIDTH    = 64,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH_LOG2    = 3,
    parameter int GLITCH_FILTER      = 2,
    parameter int TS_STEP            = 1
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [TIMESTAMP_WIDTH-1:0]    STAMP_COUNTER,
    input  logic                          ts_pulse_in,
    input  logic                          capture_en,
    input  logic [1:0]                    edge_sel,
    input  logic                          clear,
    output logic [TIMESTAMP_WIDTH-1:0]    cap_ts,
    output logic                          cap_edge,
    output logic                          cap_valid,
    input  logic                          cap_ready,
    output logic [FIFO_DEPTH_LOG2:0]      fifo_level,
    output logic [C_S_AXI_DATA_WIDTH-1:0] event_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0] overflow_count,
    output logic                          overflow
);

    localparam int TW    = TIMESTAMP_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam int GW    = (GLITCH_FILTER > 1) ? $clog2(GLITCH_FILTER) : 1;
    // The stamp at qualification is GLITCH_FILTER+1 clocks after the pin sample edge.
    localparam logic [TW-1:0] LAT_COMP   = TW'((GLITCH_FILTER + 1) * TS_STEP);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);

    logic          s1_q, s2_q;
    logic [1:0]    prime_q, prime_d;
    logic          primed;
    logic [GW-1:0] glitch_q, glitch_d;
    logic          filt_q, filt_d;
    logic          qual;

    logic          ev_valid_q, ev_valid_d;
    logic          ev_edge_q;
    logic [TW-1:0] ev_ts_q;
    logic          wr_valid_q;
    logic          wr_edge_q;
    logic [TW-1:0] wr_ts_q;

    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TW:0]   mem_q [DEPTH];
    logic [TW:0]   head;
    logic          push_req, push, pop, full, drop;

    logic [DW-1:0] evc_q, evc_d, ovc_q, ovc_d;
    logic          ovf_q, ovf_d;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= ts_pulse_in;
            s2_q <= s1_q;
        end
    end

    assign primed = (prime_q == 2'd3);

    // Priming after reset, then the glitch filter. A new level is accepted
    // only after it has differed from the filtered level for GLITCH_FILTER
    // consecutive cycles.
    always_comb begin
        prime_d  = prime_q;
        glitch_d = glitch_q;
        filt_d   = filt_q;
        qual     = 1'b0;
        if (!primed) begin
            prime_d  = prime_q + 2'd1;
            filt_d   = s2_q;
            glitch_d = '0;
        end else if (s2_q == filt_q) begin
            glitch_d = '0;
        end else if (glitch_q == GW'(GLITCH_FILTER - 1)) begin
            filt_d   = s2_q;
            glitch_d = '0;
            qual     = 1'b1;
        end else begin
            glitch_d = glitch_q + GW'(1);
        end
    end

    // Filter state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            prime_q  <= 2'd0;
            glitch_q <= '0;
            filt_q   <= 1'b0;
        end else begin
            prime_q  <= prime_d;
            glitch_q <= glitch_d;
            filt_q   <= filt_d;
        end
    end

    // The new filtered level is s2_q. edge_sel bit 0 selects rising edges and bit 1 selects falling edges.
    always_comb begin
        ev_valid_d = qual & capture_en & (s2_q ? edge_sel[0] : edge_sel[1]);
    end

    // Event register (edge E) and write stage (edge E+1). A clear kills the staged event.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ev_valid_q <= 1'b0;
            ev_edge_q  <= 1'b0;
            ev_ts_q    <= '0;
            wr_valid_q <= 1'b0;
            wr_edge_q  <= 1'b0;
            wr_ts_q    <= '0;
        end else begin
            ev_valid_q <= ev_valid_d;
            if (qual) begin
                ev_ts_q   <= STAMP_COUNTER - LAT_COMP;
                ev_edge_q <= s2_q;
            end
            wr_valid_q <= ev_valid_q & ~clear;
            if (ev_valid_q) begin
                wr_ts_q   <= ev_ts_q;
                wr_edge_q <= ev_edge_q;
            end
        end
    end

    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign cap_valid  = (fifo_level != '0);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign cap_ts     = cap_valid ? head[TW-1:0] : '0;
    assign cap_edge   = cap_valid & head[TW];

    // FIFO pointer and statistics next state. When full, a simultaneous pop
    // frees the slot that the incoming entry takes.
    always_comb begin
        full     = (fifo_level == LEVEL_FULL);
        pop      = cap_valid & cap_ready;
        push_req = wr_valid_q & ~clear;
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        evc_d    = evc_q;
        ovc_d    = ovc_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            evc_d    = '0;
            ovc_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push)       wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
            if (pop)        rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
            if (ev_valid_q) evc_d    = evc_q + DW'(1);
            if (drop) begin
                ovc_d = ovc_q + DW'(1);
                ovf_d = 1'b1;
            end
        end
    end

    // FIFO pointers and statistics registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            evc_q    <= '0;
            ovc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            evc_q    <= evc_d;
            ovc_q    <= ovc_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage. This storage has no reset because its outputs are masked while the FIFO is empty.
    always_ff @(posedge S_AXI_ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {wr_edge_q, wr_ts_q};
        end
    end

    assign event_count    = evc_q;
    assign overflow_count = ovc_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_osnt_sume_ts_capture.sv
// tb_osnt_sume_ts_capture
// Directed scenarios followed by a random phase. A reference model tracks the
// pin samples and the stamp history, derives the expected events, FIFO
// occupancy and statistics, and pushes the expected entries into a scoreboard
// queue. A monitor compares against the DUT on every cycle and checks each
// popped entry.
module tb_osnt_sume_ts_capture;

    localparam int G     = 2;
    localparam int STEP  = 1;
    localparam int DEPTH = 8;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic [63:0] stamp  = 64'hFFFF_FFFF_FFFF_FF00;
    logic        pin    = 1'b0;
    logic        cap_en = 1'b0;
    logic [1:0]  esel   = 2'b00;
    logic        clr    = 1'b0;
    logic        rdy    = 1'b0;

    logic [63:0] cap_ts;
    logic        cap_edge, cap_valid, overflow;
    logic [3:0]  fifo_level;
    logic [31:0] event_count, overflow_count;

    osnt_sume_ts_capture #(
        .TIMESTAMP_WIDTH(64), .C_S_AXI_DATA_WIDTH(32), .FIFO_DEPTH_LOG2(3),
        .GLITCH_FILTER(G), .TS_STEP(STEP)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .STAMP_COUNTER(stamp),
        .ts_pulse_in(pin), .capture_en(cap_en), .edge_sel(esel), .clear(clr),
        .cap_ts(cap_ts), .cap_edge(cap_edge), .cap_valid(cap_valid),
        .cap_ready(rdy), .fifo_level(fifo_level), .event_count(event_count),
        .overflow_count(overflow_count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) stamp <= stamp + 64'(STEP);

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model.
    typedef struct {
        logic [63:0] ts;
        logic        edg;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        e;
    int          occ = 0;
    int          k   = 0;
    logic [31:0] m_evc = 0, m_ovc = 0;
    logic        m_ovf = 0, m_L = 0;
    logic [15:0] sh = 0;           // sh[i] = pin sample i edges ago
    logic [63:0] sth [16];         // sth[i] = stamp seen i edges ago
    logic        p1_v = 0, p1_e = 0, p2_v = 0, p2_e = 0;
    logic [63:0] p1_ts = 0, p2_ts = 0;
    bit          m_pop, m_full, m_ok;

    // Each edge: commit the staged write, advance the event pipeline, then qualify new edges.
    always @(posedge clk) begin
        if (!rst_n) begin
            k = 0; sh = 0; m_L = 0; occ = 0; m_evc = 0; m_ovc = 0; m_ovf = 0;
            p1_v = 0; p2_v = 0; exp_q.delete();
        end else begin
            k++;
            sh = {sh[14:0], pin};
            for (int i = 15; i > 0; i--) sth[i] = sth[i-1];
            sth[0] = stamp;
            m_pop  = (occ > 0) && rdy;
            m_full = (occ == DEPTH);
            if (clr) begin
                occ = 0; m_evc = 0; m_ovc = 0; m_ovf = 0; p2_v = 0; exp_q.delete();
            end else begin
                if (m_pop) occ--;
                if (p2_v) begin
                    if (m_full && !m_pop) begin
                        m_ovc = m_ovc + 1;
                        m_ovf = 1;
                    end else begin
                        occ++;
                        exp_q.push_back('{p2_ts, p2_e});
                    end
                end
                p2_v = p1_v; p2_ts = p1_ts; p2_e = p1_e;
                if (p1_v) m_evc = m_evc + 1;
            end
            p1_v = 0;
            if (k <= 3) begin
                m_L = sh[2];
            end else begin
                // The level flips when the last G synchronised samples all differ from it.
                m_ok = 1;
                for (int j = 0; j < G; j++)
                    if ((k - 2 - j) < 2 || sh[2+j] == m_L) m_ok = 0;
                if (m_ok) begin
                    m_L = ~m_L;
                    if (cap_en && (m_L ? esel[0] : esel[1])) begin
                        p1_v  = 1;
                        p1_ts = sth[G+1];
                        p1_e  = m_L;
                    end
                end
            end
        end
    end

    // Monitor: compare state every cycle; pop and check the scoreboard on each handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("mon_valid", 64'(cap_valid), 64'(occ != 0));
            chk("mon_level", 64'(fifo_level), 64'(occ));
            chk("mon_event_count", 64'(event_count), 64'(m_evc));
            chk("mon_overflow_count", 64'(overflow_count), 64'(m_ovc));
            chk("mon_overflow", 64'(overflow), 64'(m_ovf));
            if (cap_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL mon_pop: DUT popped ts=%0h but scoreboard empty", cap_ts);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_ts", cap_ts, e.ts);
                    chk("mon_edge", 64'(cap_edge), 64'(e.edg));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_clear();
        clr = 1'b1; tick(1); clr = 1'b0; tick(1);
    endtask

    task automatic pulse(input int w, input int gap, output logic [63:0] rise_st);
        pin = 1'b1; rise_st = stamp; tick(w); pin = 1'b0; tick(gap);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 64'(cap_valid), 64'd0);
        chk({tag, "_level"}, 64'(fifo_level), 64'd0);
        chk({tag, "_evc"}, 64'(event_count), 64'd0);
        chk({tag, "_ovc"}, 64'(overflow_count), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_ts"}, cap_ts, 64'd0);
        chk({tag, "_edge"}, 64'(cap_edge), 64'd0);
    endtask

    logic [63:0] rs [10];
    logic [63:0] s0, s1;
    int          lat;
    int          hold;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        tick(3);
        chk_reset("reset");
        @(negedge clk); rst_n = 1'b1;
        tick(4);

        // Latency and compensation.
        cap_en = 1'b1; esel = 2'b01; rdy = 1'b0;
        do_clear();
        pin = 1'b1; s0 = stamp; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (cap_valid) begin lat = i; break; end
        end
        chk("latency_edges", 64'(lat), 64'(G + 4));   // edges N..N+G+3 inclusive
        chk("lat_cap_ts", cap_ts, s0);
        chk("lat_cap_edge", 64'(cap_edge), 64'd1);
        chk("lat_event_count", 64'(event_count), 64'd1);
        tick(3); pin = 1'b0; tick(6);
        rdy = 1'b1; tick(1); rdy = 1'b0;

        // Glitch rejection, then a both-edges pulse.
        esel = 2'b11;
        do_clear();
        pin = 1'b1; tick(1); pin = 1'b0; tick(10);
        chk("glitch_evc", 64'(event_count), 64'd0);
        chk("glitch_level", 64'(fifo_level), 64'd0);
        pin = 1'b1; s0 = stamp; tick(3); pin = 1'b0; s1 = stamp; tick(10);
        chk("pulse3_level", 64'(fifo_level), 64'd2);
        chk("pulse3_evc", 64'(event_count), 64'd2);
        chk("pulse3_rise_ts", cap_ts, s0);
        chk("pulse3_rise_edge", 64'(cap_edge), 64'd1);
        rdy = 1'b1; tick(1); rdy = 1'b0;
        chk("pulse3_fall_ts", cap_ts, s1);
        chk("pulse3_gap", cap_ts - s0, 64'(3 * STEP));
        chk("pulse3_fall_edge", 64'(cap_edge), 64'd0);
        rdy = 1'b1; tick(1); rdy = 1'b0;
        chk("pulse3_empty", 64'(fifo_level), 64'd0);

        // Overflow: 10 events into 8 entries.
        esel = 2'b01;
        do_clear();
        for (int i = 0; i < 10; i++) pulse(4, 4, rs[i]);
        tick(6);
        chk("ovf_level", 64'(fifo_level), 64'd8);
        chk("ovf_evc", 64'(event_count), 64'd10);
        chk("ovf_ovc", 64'(overflow_count), 64'd2);
        chk("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_ts", cap_ts, rs[i]);
            rdy = 1'b1; tick(1); rdy = 1'b0;
        end
        chk("drain_empty", 64'(cap_valid), 64'd0);

        // Full FIFO with a pop in the write cycle.
        do_clear();
        for (int i = 0; i < 8; i++) pulse(4, 4, rs[i]);
        tick(4);
        chk("full_level", 64'(fifo_level), 64'd8);
        pin = 1'b1; tick(5);
        rdy = 1'b1; tick(1); rdy = 1'b0;
        pin = 1'b0; tick(8);
        chk("fullpop_level", 64'(fifo_level), 64'd8);
        chk("fullpop_ovc", 64'(overflow_count), 64'd0);
        chk("fullpop_evc", 64'(event_count), 64'd9);
        chk("fullpop_head", cap_ts, rs[1]);

        // Clear colliding with a write.
        do_clear();
        for (int i = 0; i < 9; i++) pulse(4, 4, rs[i]);
        tick(4);
        chk("pre_clear_ovf", 64'(overflow), 64'd1);
        pin = 1'b1; tick(5);
        clr = 1'b1; tick(1); clr = 1'b0;
        pin = 1'b0;
        chk("clr_level", 64'(fifo_level), 64'd0);
        chk("clr_valid", 64'(cap_valid), 64'd0);
        chk("clr_evc", 64'(event_count), 64'd0);
        chk("clr_ovc", 64'(overflow_count), 64'd0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        tick(8);
        chk("clr_after_level", 64'(fifo_level), 64'd0);
        chk("clr_after_evc", 64'(event_count), 64'd0);

        // Reset and priming with the pin held high, then capture_en re-enable.
        pin = 1'b1; esel = 2'b11; cap_en = 1'b1;
        rst_n = 1'b0;
        tick(3);
        chk_reset("reset2");
        @(negedge clk); rst_n = 1'b1;
        tick(10);
        chk("prime_evc", 64'(event_count), 64'd0);
        chk("prime_level", 64'(fifo_level), 64'd0);
        cap_en = 1'b0; pin = 1'b0; tick(6);
        pin = 1'b1; tick(6);
        cap_en = 1'b1; tick(6);
        chk("reenable_evc", 64'(event_count), 64'd0);
        esel = 2'b10; pin = 1'b0; s0 = stamp; tick(8);
        chk("fall_level", 64'(fifo_level), 64'd1);
        chk("fall_edge", 64'(cap_edge), 64'd0);
        chk("fall_ts", cap_ts, s0);
        chk("fall_evc", 64'(event_count), 64'd1);
        rdy = 1'b1; tick(1); rdy = 1'b0;

        // Random phase: glitches, edge selection, back-pressure and occasional clears.
        do_clear();
        for (int it = 0; it < 400; it++) begin
            pin  = ~pin;
            hold = int'($urandom_range(1, 6));
            for (int h = 0; h < hold; h++) begin
                cap_en = ($urandom_range(0, 7) != 0);
                esel   = 2'($urandom_range(0, 3));
                rdy    = ($urandom_range(0, 3) == 0);
                clr    = ($urandom_range(0, 99) == 0);
                tick(1);
            end
            clr = 1'b0;
        end
        cap_en = 1'b0; rdy = 1'b1; tick(30); rdy = 1'b0;
        chk("final_level", 64'(fifo_level), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
